// File: rtl/reduce_mod_seq.sv
// reduce_mod_seq: iterative residue generator computing in_data mod MOD.
//
// Operation: the operand is first folded by summing its PERIOD-bit groups until
// it drops below 2^PERIOD (valid because 2^PERIOD == 1 mod MOD). It is then
// reduced below MOD by repeated conditional subtraction. One operand is
// processed at a time, with valid/ready handshakes on both sides.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    operand valid
//   in_ready    block can accept an operand (IDLE only)
//   in_data     operand N, unsigned
//   out_valid   residue valid (DONE only)
//   out_ready   downstream accepts residue
//   out_residue N mod MOD, held until the output handshake
//   busy        high while folding or subtracting
module reduce_mod_seq #(
  parameter int unsigned N_WIDTH = 16,
  parameter int unsigned MOD     = 21,
  parameter int unsigned PERIOD  = 6,
  localparam int unsigned NUM_G  = (N_WIDTH + PERIOD - 1) / PERIOD,
  localparam int unsigned MIN_AW = PERIOD + $clog2(NUM_G) + 1,
  localparam int unsigned ACC_W  = (N_WIDTH > MIN_AW) ? N_WIDTH : MIN_AW,
  localparam int unsigned RES_W  = $clog2(MOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_residue,
  output logic               busy
);

  // Groups covering the whole accumulator, not just the operand width.
  localparam int unsigned NUM_AG = (ACC_W + PERIOD - 1) / PERIOD;
  localparam int unsigned PAD_W  = NUM_AG * PERIOD;
  localparam int unsigned SUM_W  = ACC_W + $clog2(NUM_AG) + 1;

  localparam logic [ACC_W-1:0] FoldLim = ACC_W'(1) << PERIOD;
  localparam logic [ACC_W-1:0] ModW    = ACC_W'(MOD);

  localparam int unsigned PowMod = (32'd1 << PERIOD) % MOD;

  // Folding is only exact when 2^PERIOD == 1 mod MOD.
  if ((MOD < 3) || ((MOD % 2) == 0) || (PowMod != 1)) begin : g_bad_param
    $fatal(1, "reduce_mod_seq: illegal MOD/PERIOD combination");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFold = 2'd1;
  localparam logic [1:0] StSub  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_q, res_d;

  logic [PAD_W-1:0] acc_pad;
  logic [SUM_W-1:0] fold_sum;

  // Sum of all PERIOD-bit groups of the accumulator, top group zero-padded.
  always_comb begin
    acc_pad  = PAD_W'(acc_q);
    fold_sum = '0;
    for (int g = 0; g < int'(NUM_AG); g++) begin
      fold_sum = fold_sum + SUM_W'(acc_pad[g*PERIOD +: PERIOD]);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d   = ACC_W'(in_data);
          state_d = StFold;
        end
      end
      StFold: begin
        if (acc_q >= FoldLim) begin
          acc_d = ACC_W'(fold_sum);
        end else begin
          state_d = StSub;
        end
      end
      StSub: begin
        if (acc_q >= ModW) begin
          acc_d = acc_q - ModW;
        end else begin
          res_d   = acc_q[RES_W-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    in_ready    = (state_q == StIdle);
    busy        = (state_q == StFold) || (state_q == StSub);
    out_valid   = (state_q == StDone);
    out_residue = res_q;
  end

endmodule

// File: tb/tb_reduce_mod_seq.sv
module tb_reduce_mod_seq;

  localparam int unsigned N_WIDTH = 16;
  localparam int unsigned MOD     = 21;
  localparam int unsigned PERIOD  = 6;
  localparam int unsigned RES_W   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_WIDTH-1:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [RES_W-1:0]   out_residue;
  logic               busy;

  reduce_mod_seq #(
    .N_WIDTH(N_WIDTH),
    .MOD    (MOD),
    .PERIOD (PERIOD)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_residue(out_residue),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Edges from accept to first out_valid cycle, from the arithmetic rules.
  function automatic int lat_of(input logic [N_WIDTH-1:0] n);
    longint unsigned v = n;
    int f = 0;
    int s = 0;
    while (v >= (64'd1 << PERIOD)) begin
      longint unsigned t = 0;
      while (v != 0) begin
        t += v % (64'd1 << PERIOD);
        v  = v / (64'd1 << PERIOD);
      end
      v = t;
      f++;
    end
    while (v >= MOD) begin
      v -= MOD;
      s++;
    end
    return 2 + f + s;
  endfunction

  // Transaction-level model: 0 idle, 1 working, 2 presenting a result.
  int m_st   = 0;
  int m_cnt  = 0;
  int m_exp  = 0;
  int m_last = 0;
  bit chk_en = 1'b0;
  int n_done = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_st   = 0;
      m_last = 0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
          m_exp = int'(in_data % MOD);
          m_cnt = lat_of(in_data);
          m_st  = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_st   = 2;
            m_last = m_exp;
          end
        end
        default: if (out_ready) begin
          m_st = 0;
          n_done++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", longint'(in_ready), longint'(m_st == 0));
      check("busy", longint'(busy), longint'(m_st == 1));
      check("out_valid", longint'(out_valid), longint'(m_st == 2));
      check("out_residue", longint'(out_residue), longint'(m_last));
    end
  end

  // Present n, wait for the result, optionally stall, then release it.
  task automatic run_op(input string name, input logic [N_WIDTH-1:0] n,
                        input int exp_res, input int exp_lat, input int stall);
    int e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = n;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~n;
    e = 0;
    while (!out_valid && e < 20) begin
      @(negedge clk);
      e++;
    end
    check({name, "_latency"}, e, exp_lat);
    check({name, "_residue"}, longint'(out_residue), exp_res);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({name, "_held"}, longint'(out_residue), exp_res);
      check({name, "_no_ready"}, longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_released"}, longint'(out_valid), 0);
    check({name, "_ready_back"}, longint'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the model to hand-computed values.
    check("model_lat_ffff", lat_of(16'hFFFF), 4);
    check("model_lat_0fff", lat_of(16'h0FFF), 7);
    check("model_lat_63", lat_of(16'd63), 5);
    check("model_lat_0", lat_of(16'd0), 2);
    check("model_lat_1000", lat_of(16'd1000), 5);

    // Reset held two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_residue", longint'(out_residue), 0);
    check("rst_busy", longint'(busy), 0);
    chk_en = 1'b1;

    run_op("ffff", 16'hFFFF, 15, 4, 0);
    run_op("n63", 16'd63, 0, 5, 0);
    run_op("n40", 16'd40, 19, 3, 0);
    run_op("n5", 16'd5, 5, 2, 0);
    run_op("n0", 16'd0, 0, 2, 0);
    run_op("n0fff", 16'h0FFF, 0, 7, 0);
    run_op("n64", 16'd64, 1, 3, 0);
    run_op("bp1000", 16'd1000, 13, 5, 10);

    // Reset mid-operation: no result may appear.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
    end
    run_op("n100", 16'd100, 16, 4, 0);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : N_WIDTH'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (n_done < 100) begin
      bad++;
      $display("FAIL random_activity: got %0d expected >=100", n_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reduce_mod_seq.md
Name: reduce_mod_seq

Overview:
- Parametrised, iterative residue generator: computes the exact value N mod MOD for one N_WIDTH-bit operand per transaction.
- Uses periodic folding: sums the PERIOD-bit groups of the operand, repeated until the value is below 2^PERIOD. Then applies repeated conditional subtraction of MOD until the value is below MOD.
- Successor to the combinational fixed-modulus reducers. Adds exact (fully reduced) output, arbitrary width and modulus, and valid/ready handshakes.
- Sits between the binary-to-RNS front end and the per-channel residue arithmetic; one instance per modulus channel.

Parameters:
- N_WIDTH, 16, input operand width in bits.
- MOD, 21, modulus; must be odd and >= 3.
- PERIOD, 6, fold group width; requires 2^PERIOD mod MOD == 1. A simulation-time check fatals otherwise.
- NUM_G, derived = ceil(N_WIDTH/PERIOD), number of groups in the first fold.
- ACC_W, derived = max(N_WIDTH, PERIOD + clog2(NUM_G) + 1), accumulator width.
- RES_W, derived = clog2(MOD), residue width (5 for MOD = 21).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  N_WIDTH  operand N, unsigned.
- out_valid  output  1  residue valid.
- out_ready  input  1  downstream accepts residue.
- out_residue  output  RES_W  N mod MOD; always < MOD while out_valid is high.
- busy  output  1  high in FOLD or SUB.

Behaviour:
- Reset and reset mid-operation:
  - Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
  - rst high forces state IDLE, acc = 0, out_residue = 0, out_valid = 0, busy = 0.
  - in_ready goes to 1 on the first edge after rst deasserts.
  - rst asserted mid-operation aborts the transaction. No partial result is presented.
- State machine, IDLE / FOLD / SUB / DONE:
  - IDLE: in_ready = 1. On an edge with in_valid = 1, the operand is accepted: acc <= zero-extended in_data, next state FOLD.
  - FOLD: if acc >= 2^PERIOD, acc <= sum of all PERIOD-bit groups of acc (top group zero-padded); stay in FOLD. Otherwise acc is unchanged and next state is SUB.
  - SUB: if acc >= MOD, acc <= acc - MOD; stay in SUB. Otherwise out_residue <= acc[RES_W-1:0], out_valid <= 1, next state DONE.
  - DONE: hold out_valid and out_residue stable. On an edge with out_ready = 1, out_valid <= 0 and next state IDLE.
- Combinational flags:
  - in_ready = (state == IDLE).
  - busy = (state == FOLD) or (state == SUB).
  - in_ready is never asserted outside IDLE.
  - in_data is ignored outside an accepting edge, including in DONE; no new operand is taken in the same edge as an output handshake.
- Latency:
  - Counted in edges from the accept edge to the first cycle with out_valid high.
  - Latency = 2 + F + S, where F = number of fold iterations and S = number of subtractions.
  - Minimum is 2 (operand already < MOD).
  - Maximum for the defaults is 7 (worst case F = 2, S = 3, e.g. N = 16'h0FFF).
- Arithmetic:
  - All unsigned. Fold sums use ACC_W bits and never overflow given the derived ACC_W.
  - A fold value of exactly 2^PERIOD folds to 1.
  - A value of 2^PERIOD - 1 proceeds to SUB and reduces correctly (63 -> 0 for MOD 21).
  - S <= ceil((2^PERIOD - 1)/MOD).
- Boundaries:
  - in_data = 0 -> residue 0, latency 2.
  - in_data = 2^N_WIDTH - 1 reduces correctly.
  - out_ready held low: DONE persists indefinitely and outputs stay stable.
  - in_valid high in DONE has no effect.
  - out_ready high already in the first DONE cycle releases on the next edge.

Test Plan:
- Reset: after rst held 2 cycles, then released -> in_ready = 1, out_valid = 0, out_residue = 0, busy = 0.
- Fold path: in_data = 16'hFFFF -> acc sequence 65535 -> 141 -> 15 (via groups 63+63+15 = 141, then 13+2 = 15). out_residue = 15, out_valid high 4 edges after accept.
- Subtract path: in_data = 63 -> one FOLD cycle with no change (63 < 64), then 63 -> 42 -> 21 -> 0. out_residue = 0, latency 5. in_data = 40 -> 19, latency 3. in_data = 5 -> 5, latency 2.
- Backpressure: out_ready = 0 for 10 cycles with in_data = 1000 -> out_residue = 13 held stable, in_ready = 0. out_ready = 1 -> next edge out_valid = 0, in_ready = 1.
- Reset mid-operation: accept 16'hFFFF, assert rst on edge 2 -> no out_valid. Next operand 100 -> residue 16.
- Random regression: 10k random in_data with random in_valid/out_ready, compared against a reference % model. Repeat with MOD = 31, PERIOD = 5 and with N_WIDTH = 32, MOD = 21, PERIOD = 6.
